// File: rtl/load_store_unit.sv
// Memory-access stage: one LDR/STR per start over a held req/ack RAM handshake; start to done is 2 cycles min, next accept 3.
// Backpressure: ram_req is held until ram_ack or timeout abort; start while busy is dropped, not queued.
module load_store_unit #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        is_load,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        busy,
    output logic        done,
    output logic        fault,
    output logic [31:0] fromRam,
    output logic        ram_req,
    output logic        ram_we,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    output logic [3:0]  ram_be,
    input  logic [31:0] ram_rdata,
    input  logic        ram_ack
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } stateT;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT == 0 ? 0 : TIMEOUT - 1);

    stateT            state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       sizeQ;
    logic [1:0]       laneQ;
    logic             signExtQ;

    logic        illegal;
    logic        timeoutHit;
    logic [3:0]  beNext;
    logic [31:0] wdataNext;
    logic [7:0]  byteSel;
    logic [15:0] halfSel;
    logic [31:0] loadVal;

    assign busy = (state != IDLE);

    assign illegal = (size == 2'b11)
                   || (size == 2'b01 && addr[0])
                   || (size == 2'b10 && addr[1:0] != 2'b00);

    // An ack on the terminal-count cycle is checked first, so it wins over the abort.
    assign timeoutHit = (TIMEOUT != 0) && (cnt == LAST);

    always_comb begin
        beNext    = 4'b1111;
        wdataNext = store_data;
        case (size)
            2'b00: begin
                beNext    = 4'b0001 << addr[1:0];
                wdataNext = {4{store_data[7:0]}};
            end
            2'b01: begin
                beNext    = 4'b0011 << addr[1:0];
                wdataNext = {2{store_data[15:0]}};
            end
            default: begin
                beNext    = 4'b1111;
                wdataNext = store_data;
            end
        endcase
    end

    always_comb begin
        byteSel = ram_rdata[7:0];
        case (laneQ)
            2'd0:    byteSel = ram_rdata[7:0];
            2'd1:    byteSel = ram_rdata[15:8];
            2'd2:    byteSel = ram_rdata[23:16];
            default: byteSel = ram_rdata[31:24];
        endcase
        halfSel = laneQ[1] ? ram_rdata[31:16] : ram_rdata[15:0];
        loadVal = ram_rdata;
        case (sizeQ)
            2'b00:   loadVal = {{24{signExtQ & byteSel[7]}}, byteSel};
            2'b01:   loadVal = {{16{signExtQ & halfSel[15]}}, halfSel};
            default: loadVal = ram_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            sizeQ     <= 2'b00;
            laneQ     <= 2'b00;
            signExtQ  <= 1'b0;
            done      <= 1'b0;
            fault     <= 1'b0;
            fromRam   <= 32'h0;
            ram_req   <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= 32'h0;
            ram_wdata <= 32'h0;
            ram_be    <= 4'h0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sizeQ    <= size;
                        laneQ    <= addr[1:0];
                        signExtQ <= sign_ext;
                        fault    <= illegal;
                        cnt      <= '0;
                        if (illegal) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state     <= REQ;
                            ram_req   <= 1'b1;
                            ram_we    <= ~is_load;
                            ram_addr  <= {addr[31:2], 2'b00};
                            ram_wdata <= is_load ? 32'h0 : wdataNext;
                            ram_be    <= beNext;
                        end
                    end
                end
                REQ: begin
                    if (ram_ack || timeoutHit) begin
                        if (ram_ack && !ram_we) begin
                            fromRam <= loadVal;
                        end
                        fault     <= ~ram_ack;
                        state     <= DONE;
                        done      <= 1'b1;
                        ram_req   <= 1'b0;
                        ram_we    <= 1'b0;
                        ram_addr  <= 32'h0;
                        ram_wdata <= 32'h0;
                        ram_be    <= 4'h0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit (TIMEOUT=4): directed cases plus a randomized back-to-back run
// checked against a byte-lane reference model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        is_load;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        busy;
    logic        done;
    logic        fault;
    logic [31:0] fromRam;
    logic        ram_req;
    logic        ram_we;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [3:0]  ram_be;
    logic [31:0] ram_rdata;
    logic        ram_ack;

    int total = 0;
    int bad   = 0;

    int          oReq, oDone, oDoneCyc, oCyc;
    logic        oFault, oFault1, oWe, oBadBus, oTimedOut;
    logic [31:0] oAddr, oWdata;
    logic [3:0]  oBe;

    load_store_unit #(.TIMEOUT(4), .CNT_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .is_load    (is_load),
        .size       (size),
        .sign_ext   (sign_ext),
        .addr       (addr),
        .store_data (store_data),
        .busy       (busy),
        .done       (done),
        .fault      (fault),
        .fromRam    (fromRam),
        .ram_req    (ram_req),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_be     (ram_be),
        .ram_rdata  (ram_rdata),
        .ram_ack    (ram_ack)
    );

    always #5 clk = ~clk;

    function automatic int nBytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic refLegal(input logic [1:0] sz, input logic [31:0] a);
        return (sz != 2'd3) && ((a % nBytes(sz)) == 0);
    endfunction

    function automatic logic [3:0] refBe(input logic [1:0] sz, input logic [31:0] a);
        int m;
        m = ((1 << nBytes(sz)) - 1) << (a % 4);
        return m[3:0];
    endfunction

    function automatic logic [31:0] refWdata(input logic [1:0] sz, input logic [31:0] sd);
        logic [31:0] w;
        w = 32'h0;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = sd[8*(i % nBytes(sz)) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] refLoad(input logic [1:0] sz, input logic sx,
                                            input logic [31:0] a, input logic [31:0] rd);
        logic [63:0] v, mask;
        int nb;
        nb   = nBytes(sz);
        v    = {32'h0, rd} >> (8 * (a % 4));
        mask = (64'd1 << (8 * nb)) - 64'd1;
        v    = v & mask;
        if (sx && v[8*nb-1]) v = v | ~mask;
        return v[31:0];
    endfunction

    // Runs one access starting at posedge+1 and returns at posedge+1 of the first IDLE cycle.
    task automatic doAccess(input logic ld, input logic [1:0] sz, input logic sx,
                            input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rd,
                            input int ackAfter, input logic poke);
        oReq = 0; oDone = 0; oDoneCyc = 0; oCyc = 0;
        oFault = 1'b0; oFault1 = 1'b0; oWe = 1'b0; oBadBus = 1'b0; oTimedOut = 1'b1;
        oAddr = 32'h0; oWdata = 32'h0; oBe = 4'h0;
        is_load = ld; size = sz; sign_ext = sx; addr = a; store_data = sd; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; is_load = ~ld; sign_ext = ~sx; size = 2'($urandom);
        addr = $urandom; store_data = $urandom;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            if (cyc == 1) oFault1 = fault;
            if (!busy) begin
                oTimedOut = 1'b0;
                oCyc = cyc;
                break;
            end
            if (ram_req) begin
                oReq++;
                if (oReq == 1) begin
                    oWe = ram_we; oAddr = ram_addr; oWdata = ram_wdata; oBe = ram_be;
                end else if ({ram_we, ram_addr, ram_wdata, ram_be} !== {oWe, oAddr, oWdata, oBe}) begin
                    oBadBus = 1'b1;
                end
                if (ackAfter >= 0 && oReq == ackAfter + 1) begin
                    ram_ack = 1'b1;
                    ram_rdata = rd;
                end
            end else if ({ram_we, ram_addr, ram_wdata, ram_be} !== 69'h0) begin
                oBadBus = 1'b1;
            end
            if (done) begin
                oDone++;
                oDoneCyc = cyc;
                oFault = fault;
                if (poke && oDone == 1) begin
                    start = 1'b1; is_load = 1'b1; size = 2'd2; addr = 32'h200;
                end
            end
            @(posedge clk); #1;
            ram_ack = 1'b0; ram_rdata = $urandom; start = 1'b0;
        end
    endtask

    task automatic test_reset;
        reset = 1'b0; start = 1'b0; is_load = 1'b0; size = 2'd0; sign_ext = 1'b0;
        addr = 32'h0; store_data = 32'h0; ram_rdata = 32'h0; ram_ack = 1'b0;
        #2 reset = 1'b1;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0 || fault !== 1'b0) begin bad++; $display("FAIL rst_done_fault got=%b%b exp=00", done, fault); end
        total++; if (fromRam !== 32'h0) begin bad++; $display("FAIL rst_fromRam got=%h exp=0", fromRam); end
        total++; if ({ram_req, ram_we, ram_addr, ram_wdata, ram_be} !== 70'h0) begin bad++; $display("FAIL rst_ram_bus got=%b/%b/%h/%h/%b exp=0", ram_req, ram_we, ram_addr, ram_wdata, ram_be); end
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_load_word;
        doAccess(1'b1, 2'd2, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 2, 1'b0);
        total++; if (oTimedOut) begin bad++; $display("FAIL lw_bound got=stuck exp=idle"); end
        total++; if (oAddr !== 32'h100 || oBe !== 4'b1111 || oWe !== 1'b0) begin bad++; $display("FAIL lw_bus got=%h/%b/%b exp=00000100/1111/0", oAddr, oBe, oWe); end
        total++; if (fromRam !== 32'hDEADBEEF) begin bad++; $display("FAIL lw_fromRam got=%h exp=deadbeef", fromRam); end
        total++; if (oDone !== 1 || oFault !== 1'b0) begin bad++; $display("FAIL lw_done got=%0d/%b exp=1/0", oDone, oFault); end
        total++; if (oReq !== 3 || oDoneCyc !== 4 || oCyc !== 5) begin bad++; $display("FAIL lw_timing got=%0d/%0d/%0d exp=3/4/5", oReq, oDoneCyc, oCyc); end
    endtask

    task automatic test_load_byte;
        doAccess(1'b1, 2'd0, 1'b1, 32'h103, 32'h0, 32'h80FF0011, 0, 1'b0);
        total++; if (fromRam !== 32'hFFFFFF80) begin bad++; $display("FAIL lb_signed got=%h exp=ffffff80", fromRam); end
        total++; if (oBe !== 4'b1000 || oAddr !== 32'h100) begin bad++; $display("FAIL lb_bus got=%b/%h exp=1000/00000100", oBe, oAddr); end
        total++; if (oReq !== 1 || oDoneCyc !== 2 || oCyc !== 3) begin bad++; $display("FAIL lb_latency got=%0d/%0d/%0d exp=1/2/3", oReq, oDoneCyc, oCyc); end
        doAccess(1'b1, 2'd0, 1'b0, 32'h103, 32'h0, 32'h80FF0011, 1, 1'b0);
        total++; if (fromRam !== 32'h00000080) begin bad++; $display("FAIL lb_unsigned got=%h exp=00000080", fromRam); end
    endtask

    task automatic test_store_half;
        doAccess(1'b0, 2'd1, 1'b0, 32'h22, 32'h1234ABCD, 32'h55555555, 1, 1'b0);
        total++; if (oWe !== 1'b1 || oAddr !== 32'h20 || oBe !== 4'b1100) begin bad++; $display("FAIL sh_bus got=%b/%h/%b exp=1/00000020/1100", oWe, oAddr, oBe); end
        total++; if (oWdata !== 32'hABCDABCD) begin bad++; $display("FAIL sh_wdata got=%h exp=abcdabcd", oWdata); end
        total++; if (fromRam !== 32'h00000080) begin bad++; $display("FAIL sh_fromRam got=%h exp=00000080", fromRam); end
        total++; if (oBadBus !== 1'b0) begin bad++; $display("FAIL sh_stable got=%b exp=0", oBadBus); end
    endtask

    task automatic test_illegal;
        doAccess(1'b1, 2'd2, 1'b0, 32'h102, 32'h0, 32'h0, 0, 1'b0);
        total++; if (oReq !== 0 || oDoneCyc !== 1 || oFault !== 1'b1) begin bad++; $display("FAIL ill_word got=%0d/%0d/%b exp=0/1/1", oReq, oDoneCyc, oFault); end
        repeat (2) @(posedge clk);
        #1;
        total++; if (fault !== 1'b1) begin bad++; $display("FAIL ill_fault_held got=%b exp=1", fault); end
        doAccess(1'b0, 2'd3, 1'b0, 32'h100, 32'h0, 32'h0, 0, 1'b0);
        total++; if (oReq !== 0 || oDoneCyc !== 1 || oFault !== 1'b1 || oDone !== 1) begin bad++; $display("FAIL ill_size got=%0d/%0d/%b/%0d exp=0/1/1/1", oReq, oDoneCyc, oFault, oDone); end
        doAccess(1'b0, 2'd2, 1'b0, 32'h104, 32'h0, 32'h0, 0, 1'b0);
        total++; if (oFault1 !== 1'b0 || oFault !== 1'b0) begin bad++; $display("FAIL ill_fault_clear got=%b/%b exp=0/0", oFault1, oFault); end
        total++; if (fromRam !== 32'h00000080) begin bad++; $display("FAIL ill_fromRam got=%h exp=00000080", fromRam); end
    endtask

    task automatic test_timeout;
        doAccess(1'b1, 2'd2, 1'b0, 32'h300, 32'h0, 32'h0, -1, 1'b1);
        total++; if (oReq !== 4) begin bad++; $display("FAIL to_req_cycles got=%0d exp=4", oReq); end
        total++; if (oDone !== 1 || oDoneCyc !== 5 || oFault !== 1'b1) begin bad++; $display("FAIL to_done got=%0d/%0d/%b exp=1/5/1", oDone, oDoneCyc, oFault); end
        total++; if (oCyc !== 6 || ram_req !== 1'b0) begin bad++; $display("FAIL to_poke_ignored got=%0d/%b exp=6/0", oCyc, ram_req); end
        total++; if (fromRam !== 32'h00000080) begin bad++; $display("FAIL to_fromRam got=%h exp=00000080", fromRam); end
    endtask

    task automatic test_reset_mid_req;
        is_load = 1'b1; size = 2'd2; sign_ext = 1'b0; addr = 32'h40; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #2;
        total++; if (ram_req !== 1'b1) begin bad++; $display("FAIL mid_req_before got=%b exp=1", ram_req); end
        reset = 1'b1;
        #1;
        total++; if ({ram_req, busy, done} !== 3'b000 || fromRam !== 32'h0) begin bad++; $display("FAIL mid_reset got=%b%b%b/%h exp=000/0", ram_req, busy, done, fromRam); end
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL mid_no_done got=%b%b exp=00", done, busy); end
        doAccess(1'b1, 2'd1, 1'b1, 32'h42, 32'h0, 32'h9876_1234, 0, 1'b0);
        total++; if (fromRam !== 32'hFFFF9876 || oDoneCyc !== 2 || oFault !== 1'b0) begin bad++; $display("FAIL mid_after got=%h/%0d/%b exp=ffff9876/2/0", fromRam, oDoneCyc, oFault); end
    endtask

    task automatic test_random_back_to_back;
        logic        ld, sx, legal;
        logic [1:0]  sz;
        logic [31:0] a, sd, rd, expFrom;
        int          ackAfter, r;
        expFrom = fromRam;
        for (int n = 0; n < 60; n++) begin
            ld = 1'($urandom); sx = 1'($urandom); sz = 2'($urandom);
            a = $urandom; sd = $urandom; rd = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = (sz == 2'd2) ? 2'd0 : (sz == 2'd1) ? {a[1], 1'b0} : a[1:0];
            r = $urandom_range(0, 7);
            ackAfter = (r == 0) ? -1 : (r % 4);
            legal = refLegal(sz, a);
            doAccess(ld, sz, sx, a, sd, rd, ackAfter, 1'b0);
            total++; if (oTimedOut || oDone !== 1 || oCyc !== oDoneCyc + 1) begin bad++; $display("FAIL rnd%0d_handshake got=%b/%0d/%0d/%0d", n, oTimedOut, oDone, oDoneCyc, oCyc); end
            if (!legal) begin
                total++; if (oReq !== 0 || oDoneCyc !== 1 || oFault !== 1'b1) begin bad++; $display("FAIL rnd%0d_illegal got=%0d/%0d/%b exp=0/1/1", n, oReq, oDoneCyc, oFault); end
            end else if (ackAfter < 0) begin
                total++; if (oReq !== 4 || oDoneCyc !== 5 || oFault !== 1'b1) begin bad++; $display("FAIL rnd%0d_timeout got=%0d/%0d/%b exp=4/5/1", n, oReq, oDoneCyc, oFault); end
            end else begin
                total++; if (oReq !== ackAfter + 1 || oDoneCyc !== ackAfter + 2 || oFault !== 1'b0 || oFault1 !== 1'b0) begin bad++; $display("FAIL rnd%0d_ok got=%0d/%0d/%b exp=%0d/%0d/0", n, oReq, oDoneCyc, oFault, ackAfter + 1, ackAfter + 2); end
                total++; if (oWe !== ~ld || oAddr !== {a[31:2], 2'b00} || oBe !== refBe(sz, a) || oBadBus !== 1'b0) begin bad++; $display("FAIL rnd%0d_bus got=%b/%h/%b/%b exp=%b/%h/%b/0", n, oWe, oAddr, oBe, oBadBus, ~ld, {a[31:2], 2'b00}, refBe(sz, a)); end
                if (!ld) begin
                    total++; if (oWdata !== refWdata(sz, sd)) begin bad++; $display("FAIL rnd%0d_wdata got=%h exp=%h", n, oWdata, refWdata(sz, sd)); end
                end else begin
                    expFrom = refLoad(sz, sx, a, rd);
                end
            end
            total++; if (fromRam !== expFrom) begin bad++; $display("FAIL rnd%0d_fromRam got=%h exp=%h", n, fromRam, expFrom); end
        end
    endtask

    initial begin
        test_reset();
        test_load_word();
        test_load_byte();
        test_store_half();
        test_illegal();
        test_timeout();
        test_reset_mid_req();
        test_random_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
